activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
- Multi-channel, mode-selectable activation stage placed between the neuron MAC accumulators and the next layer's input buffer.
- Converts each channel's double-width fixed-point accumulator to a single-width output, with signed saturation.
- Supported modes: ReLU, leaky ReLU, linear saturate, clamped ReLU.
- Two-stage pipeline with valid/ready flow control and a sticky saturation-event counter for debug and quantisation tuning.

Parameters:
- DATA_WIDTH, 16, width of one output sample and of one layer input/weight word.
- WEIGHT_INT_WIDTH, 4, integer bits of the weight format. Sets where the output slice sits in the accumulator.
- NUM_CH, 4, number of parallel channels processed per beat.
- LEAK_SHIFT, 3, arithmetic right-shift applied to negative values in leaky mode (slope 2^-LEAK_SHIFT).
- CLAMP_MAX, 16'h0600, upper bound for clamped-ReLU mode. Positive, DATA_WIDTH bits.
- CNT_WIDTH, 16, width of the saturation-event counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mode  in  2  activation select, sampled with each accepted beat: 0 ReLU, 1 leaky, 2 linear saturate, 3 clamped ReLU
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- data_in  in  NUM_CH*2*DATA_WIDTH  packed accumulators; channel k occupies bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH]. Format per channel: sign, weight int, input int, weight frac, input frac.
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- data_out  out  NUM_CH*DATA_WIDTH  packed results; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- sat_clear  in  1  synchronous clear of sat_cnt
- sat_cnt  out  CNT_WIDTH  number of accepted beats in which at least one lane overflow-saturated

Behaviour:
- Reset (asynchronous, active-high): both pipeline stage valids = 0, out_valid = 0, data_out = 0, sat_cnt = 0, registered mode = 0.
- Flow control:
  - Pipeline advance enable en = !out_valid || out_ready.
  - in_ready = en, purely combinational from out_valid/out_ready.
  - An input beat is accepted when in_valid && in_ready.
  - When en = 0, all stages hold their contents and no data is dropped or duplicated.
  - Latency is 2 cycles from acceptance to out_valid when downstream never stalls; throughput is 1 beat per cycle.
  - out_valid/data_out stay stable while out_valid && !out_ready.
- Stage 1 (per lane, on acceptance): register the accumulator x and mode.
  - Leaky mode with x negative: register x >>> LEAK_SHIFT instead of x (arithmetic shift on the full 2*DATA_WIDTH word, truncation toward minus infinity).
- Stage 2 (per lane):
  - Slice S = x[2*DATA_WIDTH-1-WEIGHT_INT_WIDTH -: DATA_WIDTH].
  - ovf = the top WEIGHT_INT_WIDTH+1 bits of x are not all equal.
  - Signed saturated value V:
    - ovf && x positive → 0x7FFF (max positive)
    - ovf && x negative → 0x8000 (min negative)
    - otherwise → S
  - Mode 0: x negative → 0, else V.
  - Mode 1: V (negative input already shifted).
  - Mode 2: V.
  - Mode 3: x negative → 0; else min(V, CLAMP_MAX).
  - Zero is treated as non-negative in every mode.
- Saturation counter:
  - Increments by 1 when a beat moves from stage 1 to stage 2 and any lane has ovf = 1.
  - Lanes zeroed by ReLU do not count. Clamping to CLAMP_MAX alone does not count.
  - Holds at the all-ones value; it does not wrap.
  - If sat_clear and an increment occur in the same cycle, sat_cnt becomes 0 (clear wins).
- Mode can change on every beat; each beat uses the mode captured with it.
- Asserting rst mid-stream flushes the pipeline; in-flight beats are discarded.

Test Plan:
- Mode 0, one beat, lane0 = 0x00012000, lane1 = 0xFFFFF000, lanes 2/3 = 0, out_ready = 1 → out_valid 2 cycles after acceptance; lane0 = 0x0012, lane1 = 0x0000, others 0; sat_cnt = 0.
- Mode 0, lane0 = 0x10000000 (positive overflow); mode 2, lane0 = 0x80000000 → outputs 0x7FFF then 0x8000; sat_cnt = 2; then pulse sat_clear → sat_cnt = 0.
- Mode 1 with LEAK_SHIFT = 3: lane0 = 0xFFFF8000 → 0xFFFF (-1); lane1 = 0x00008000 → 0x0008; lane2 = 0x00000000 → 0x0000.
- Mode 3 with CLAMP_MAX = 0x0600: lane0 = 0x01000000 → 0x0600; lane1 = 0x00400000 → 0x0400; lane2 = 0xF0000000 → 0x0000; sat_cnt unchanged.
- Back-to-back stream of 8 beats with alternating modes, out_ready held low for 3 cycles mid-stream → in_ready drops while stalled; all 8 results emerge in order, each matching its own mode, none lost or repeated.
- Assert rst while 2 beats are in flight → out_valid = 0, data_out = 0, sat_cnt = 0 immediately; the next accepted beat produces a correct result 2 cycles later.

Source files
------------

// File: rtl/activation_unit.sv
// Multi-lane activation stage: narrows double-width MAC accumulators to single width
// with signed saturation, four activation modes, a 2-stage valid/ready pipeline and a sticky overflow counter.
module activation_unit #(
  parameter int                  DATA_WIDTH       = 16,
  parameter int                  WEIGHT_INT_WIDTH = 4,
  parameter int                  NUM_CH           = 4,
  parameter int                  LEAK_SHIFT       = 3,
  parameter logic [DATA_WIDTH-1:0] CLAMP_MAX      = 16'h0600,
  parameter int                  CNT_WIDTH        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0] data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
  input  logic                           sat_clear,
  output logic [CNT_WIDTH-1:0]           sat_cnt
);

  localparam int ACC_W     = 2 * DATA_WIDTH;
  localparam int TOP_W     = WEIGHT_INT_WIDTH + 1;
  localparam int SLICE_MSB = ACC_W - 1 - WEIGHT_INT_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_RELU   = 2'd0,
    MODE_LEAKY  = 2'd1,
    MODE_LINEAR = 2'd2,
    MODE_CLAMP  = 2'd3
  } mode_e;

  logic                    en;
  logic                    accept;
  logic                    s1_valid;
  mode_e                   s1_mode;
  logic signed [ACC_W-1:0] acc_in [NUM_CH];
  logic signed [ACC_W-1:0] s1_x_d [NUM_CH];
  logic signed [ACC_W-1:0] s1_x   [NUM_CH];

  logic [NUM_CH-1:0]             neg;
  logic [NUM_CH-1:0]             ovf;
  logic [NUM_CH-1:0]             lane_sat;
  logic [DATA_WIDTH-1:0]         sat_v [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0]  data_d;
  logic                          relu_mode;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign acc_in[g] = data_in[g*ACC_W +: ACC_W];
  end

  // Leaky slope is applied before narrowing so small negatives keep their fraction bits.
  always_comb begin
    s1_x_d = acc_in;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mode_e'(mode) == MODE_LEAKY && acc_in[k][ACC_W-1])
        s1_x_d[k] = acc_in[k] >>> LEAK_SHIFT;
    end
  end

  assign relu_mode = (s1_mode == MODE_RELU) || (s1_mode == MODE_CLAMP);

  always_comb begin
    neg      = '0;
    ovf      = '0;
    lane_sat = '0;
    sat_v    = '{default: '0};
    data_d   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      neg[k] = s1_x[k][ACC_W-1];
      ovf[k] = (s1_x[k][ACC_W-1 -: TOP_W] != {TOP_W{1'b0}}) &&
               (s1_x[k][ACC_W-1 -: TOP_W] != {TOP_W{1'b1}});
      if (ovf[k])
        sat_v[k] = neg[k] ? MIN_NEG : MAX_POS;
      else
        sat_v[k] = s1_x[k][SLICE_MSB -: DATA_WIDTH];

      if (relu_mode && neg[k])
        data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (s1_mode == MODE_CLAMP && sat_v[k] > CLAMP_MAX)
        data_d[k*DATA_WIDTH +: DATA_WIDTH] = CLAMP_MAX;
      else
        data_d[k*DATA_WIDTH +: DATA_WIDTH] = sat_v[k];

      // A lane that ReLU forces to zero never reaches the output, so its overflow is irrelevant.
      lane_sat[k] = ovf[k] && !(relu_mode && neg[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_RELU;
      s1_x      <= '{default: '0};
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (en) begin
      s1_valid  <= accept;
      if (accept) begin
        s1_x    <= s1_x_d;
        s1_mode <= mode_e'(mode);
      end
      out_valid <= s1_valid;
      if (s1_valid)
        data_out <= data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_cnt <= '0;
    else if (sat_clear)
      sat_cnt <= '0;
    else if (en && s1_valid && (|lane_sat) && (sat_cnt != {CNT_WIDTH{1'b1}}))
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed-vector bench for activation_unit: single beats per mode, counter clear,
// a stalled back-to-back stream and a mid-stream reset.
module tb_activation_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  data_out;
  logic         sat_clear;
  logic [15:0]  sat_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]   mode;
    logic [127:0] x;    // {lane3, lane2, lane1, lane0}
    logic [63:0]  y;
    logic         inc;
  } vec_t;

  vec_t vecs [10];

  activation_unit dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sat_clear (sat_clear),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    mode     = vecs[i].mode;
    data_in  = vecs[i].x;
    in_valid = 1'b1;
  endtask

  // Called #1 after a rising edge with out_ready high.
  task automatic single(input int i, input logic [15:0] exp_sat);
    drive(i);
    @(negedge clk);
    chk($sformatf("in_ready_v%0d", i), 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = '0;
    chk($sformatf("latency1_v%0d", i), 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    chk($sformatf("out_valid_v%0d", i), 128'(out_valid), 128'(1));
    chk($sformatf("data_v%0d", i), 128'(data_out), 128'(vecs[i].y));
    chk($sformatf("sat_cnt_v%0d", i), 128'(sat_cnt), 128'(exp_sat));
  endtask

  logic [15:0] exp_sat;
  int          rx;
  logic        stall_seen;
  logic        prev_stall;
  logic [63:0] held;

  initial begin
    vecs[0] = '{2'd0, {32'h00000000, 32'h00000000, 32'hFFFFF000, 32'h00012000}, {16'h0000, 16'h0000, 16'h0000, 16'h0012}, 1'b0};
    vecs[1] = '{2'd1, {32'h00123000, 32'h00000000, 32'h00008000, 32'hFFFF8000}, {16'h0123, 16'h0000, 16'h0008, 16'hFFFF}, 1'b0};
    vecs[2] = '{2'd2, {32'h00012000, 32'h7FFFFFFF, 32'hFFFFF000, 32'h80000000}, {16'h0012, 16'h7FFF, 16'hFFFF, 16'h8000}, 1'b1};
    vecs[3] = '{2'd3, {32'h00600000, 32'hF0000000, 32'h00400000, 32'h01000000}, {16'h0600, 16'h0000, 16'h0400, 16'h0600}, 1'b0};
    vecs[4] = '{2'd0, {32'h00000000, 32'h00400000, 32'h80000000, 32'h10000000}, {16'h0000, 16'h0400, 16'h0000, 16'h7FFF}, 1'b1};
    vecs[5] = '{2'd1, {32'h00000000, 32'h00008000, 32'hFFFFFFF8, 32'h80000000}, {16'h0000, 16'h0008, 16'hFFFF, 16'h8000}, 1'b1};
    vecs[6] = '{2'd2, {32'h00001000, 32'h00000000, 32'hF8000000, 32'h07FFF000}, {16'h0001, 16'h0000, 16'h8000, 16'h7FFF}, 1'b0};
    vecs[7] = '{2'd3, {32'h005FF000, 32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF}, {16'h05FF, 16'h0000, 16'h0000, 16'h0600}, 1'b1};
    vecs[8] = '{2'd0, {32'hFFFF0000, 32'h07FFF000, 32'h00000000, 32'h80000000}, {16'h0000, 16'h7FFF, 16'h0000, 16'h0000}, 1'b0};
    vecs[9] = '{2'd2, {32'h00000000, 32'h00000000, 32'h00000000, 32'h08000000}, {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 1'b1};

    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1; sat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_data_out",  128'(data_out),  128'(0));
    chk("reset_sat_cnt",   128'(sat_cnt),   128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    exp_sat = 16'd0;
    for (int i = 0; i < 10; i++) begin
      exp_sat = exp_sat + 16'(vecs[i].inc);
      single(i, exp_sat);
    end

    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    chk("sat_clear", 128'(sat_cnt), 128'(0));

    // Clear lands on the same edge as an overflow beat's increment.
    drive(9);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    chk("clear_wins_valid", 128'(out_valid), 128'(1));
    chk("clear_wins_data",  128'(data_out),  128'(vecs[9].y));
    chk("clear_wins_sat",   128'(sat_cnt),   128'(0));
    @(posedge clk); #1;

    rx = 0; stall_seen = 1'b0; prev_stall = 1'b0; held = '0;
    fork
      begin : drv
        for (int b = 0; b < 8; b++) begin
          logic acc;
          int   w;
          drive(b);
          acc = 1'b0;
          w   = 0;
          while (!acc && w < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            w++;
          end
          chk($sformatf("stream_accept_%0d", b), 128'(acc), 128'(1));
        end
        in_valid = 1'b0;
      end
      begin : rdy
        for (int c = 0; c < 12; c++) begin
          @(posedge clk); #1;
          out_ready = !(c >= 4 && c < 7);
        end
      end
      begin : mon
        for (int c = 0; c < 60 && rx < 8; c++) begin
          @(negedge clk);
          if (out_valid && prev_stall)
            chk("stall_hold", 128'(data_out), 128'(held));
          if (out_valid && !out_ready) begin
            stall_seen = 1'b1;
            chk("stall_in_ready", 128'(in_ready), 128'(0));
          end
          prev_stall = out_valid && !out_ready;
          held       = data_out;
          if (out_valid && out_ready) begin
            chk($sformatf("stream_%0d", rx), 128'(data_out), 128'(vecs[rx].y));
            rx++;
          end
        end
      end
    join
    chk("stream_count", 128'(rx), 128'(8));
    chk("stall_seen", 128'(stall_seen), 128'(1));
    @(negedge clk);
    chk("stream_drained", 128'(out_valid), 128'(0));
    chk("stream_sat", 128'(sat_cnt), 128'(4));

    @(posedge clk); #1;
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;

    // Two beats in flight, then an asynchronous reset.
    drive(2);
    @(posedge clk); #1;
    drive(4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", 128'(out_valid), 128'(1));
    chk("pre_rst_sat",   128'(sat_cnt),   128'(1));
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out",  128'(data_out),  128'(0));
    chk("rst_sat_cnt",   128'(sat_cnt),   128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_flushed", 128'(out_valid), 128'(0));
    single(1, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
